latch_write_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one WIDTH-bit Dlatch bank between N requesters in the decode datapath. It grants one requester at a time and sequences the latch safely: data setup with enable low, then a one-cycle transparent window, then a hold phase with data still stable. It checks the latch readback in the hold phase and returns a per-requester acknowledge. It sits between the decode-stage producers and the shared latch bank, and owns that bank's en/d pins.

---
 rtl/latch_write_arbiter.sv | 71 +++++++
 tb/tb_latch_write_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/latch_write_arbiter.sv
// latch_write_arbiter: round-robin arbiter sequencing writes into a shared Dlatch bank
// with setup, a one-cycle transparent window, and a checked hold phase.
module latch_write_arbiter #(
  parameter int WIDTH     = 32,
  parameter int N         = 4,
  parameter int SETUP_CYC = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   wdata,
  output logic [N-1:0]         ack,
  output logic                 latch_en,
  output logic [WIDTH-1:0]     latch_d,
  input  logic [WIDTH-1:0]     latch_q,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 err
);
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;
  state_t state;
  logic [IW-1:0] last, sel;
  logic [2:0] cnt;
  // Descending scan so the nearest requester after last overwrites the others.
  always_comb begin
    sel = last;
    for (int k = N; k >= 1; k--)
      if (req[(int'(last) + k) % N]) sel = IW'((int'(last) + k) % N);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      latch_en <= 1'b0;
      latch_d  <= '0;
      ack      <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      cnt      <= '0;
      last     <= IW'(N - 1);
    end else begin
      case (state)
        IDLE: if (|req) begin
          grant_id <= sel;
          latch_d  <= wdata[int'(sel)*WIDTH +: WIDTH];
          cnt      <= 3'(SETUP_CYC - 1);
          busy     <= 1'b1;
          state    <= SETUP;
        end
        SETUP: if (cnt == '0) begin
          latch_en <= 1'b1;
          state    <= OPEN;
        end else cnt <= cnt - 3'd1;
        OPEN: begin
          latch_en <= 1'b0;
          ack      <= {{(N-1){1'b0}}, 1'b1} << grant_id;
          state    <= HOLD;
        end
        HOLD: begin
          ack   <= '0;
          err   <= err | (latch_q != latch_d);
          last  <= grant_id;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_latch_write_arbiter.sv
// tb_latch_write_arbiter: directed checks of arbitration order, latch sequencing,
// readback error flag and asynchronous reset.
module tb_latch_write_arbiter;
  logic clk = 1'b0, reset = 1'b0, bad = 1'b0;
  logic [3:0] req = '0, ack, req3 = '0, ack3;
  logic [127:0] wdata = '0, wdata3 = '0;
  logic latch_en, busy, err, en3, busy3, err3;
  logic [31:0] latch_d, latch_q, lq, d3, q3;
  logic [1:0] grant_id, gid3;
  int n_chk = 0, n_fail = 0;

  latch_write_arbiter #(.WIDTH(32), .N(4), .SETUP_CYC(1)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .ack(ack),
    .latch_en(latch_en), .latch_d(latch_d), .latch_q(latch_q),
    .grant_id(grant_id), .busy(busy), .err(err));

  latch_write_arbiter #(.WIDTH(32), .N(4), .SETUP_CYC(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .wdata(wdata3), .ack(ack3),
    .latch_en(en3), .latch_d(d3), .latch_q(q3),
    .grant_id(gid3), .busy(busy3), .err(err3));

  always #5 clk = ~clk;
  always_latch if (latch_en) lq <= latch_d;
  always_latch if (en3) q3 <= d3;
  assign latch_q = bad ? 32'h0 : lq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One full write by requester id, starting from the negedge before the grant edge.
  task automatic xfer(input int id, input logic [31:0] d);
    @(negedge clk);
    check("setup_gid", 32'(grant_id), id);
    check("setup_d", latch_d, d);
    check("setup_en", 32'(latch_en), 0);
    check("setup_busy", 32'(busy), 1);
    @(negedge clk);
    check("open_en", 32'(latch_en), 1);
    check("open_d", latch_d, d);
    check("open_ack", 32'(ack), 0);
    @(negedge clk);
    check("hold_ack", 32'(ack), 32'(1) << id);
    check("hold_en", 32'(latch_en), 0);
    check("hold_d", latch_d, d);
    req[id] = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_ack", 32'(ack), 0);
  endtask

  initial begin
    @(negedge clk);
    check("rst_en", 32'(latch_en), 0);
    check("rst_d", latch_d, 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_gid", 32'(grant_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    reset = 1'b1;
    @(negedge clk);
    wdata[31:0] = 32'hDEADBEEF;
    req = 4'b0001;
    xfer(0, 32'hDEADBEEF);
    check("first_err", 32'(err), 0);
    do_reset();
    wdata = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    req = 4'b1111;
    xfer(0, 32'h11111111);
    xfer(1, 32'h22222222);
    xfer(2, 32'h33333333);
    xfer(3, 32'h44444444);
    req = 4'b0100;
    xfer(2, 32'h33333333);
    req = 4'b0101;
    xfer(0, 32'h11111111);
    xfer(2, 32'h33333333);
    bad = 1'b1;
    wdata[31:0] = 32'hA5A5A5A5;
    req = 4'b0001;
    xfer(0, 32'hA5A5A5A5);
    check("err_set", 32'(err), 1);
    bad = 1'b0;
    wdata[63:32] = 32'h0F0F0F0F;
    req = 4'b0010;
    xfer(1, 32'h0F0F0F0F);
    check("err_sticky", 32'(err), 1);
    do_reset();
    check("err_cleared", 32'(err), 0);
    wdata[31:0] = 32'h600DF00D;
    req = 4'b0001;
    repeat (2) @(negedge clk);
    check("pre_rst_open", 32'(latch_en), 1);
    #2 reset = 1'b0;
    #1;
    check("async_en", 32'(latch_en), 0);
    check("async_busy", 32'(busy), 0);
    req = 4'b0010;
    wdata[63:32] = 32'hCAFE0001;
    @(negedge clk);
    reset = 1'b1;
    xfer(1, 32'hCAFE0001);
    wdata3[31:0] = 32'h12345678;
    req3 = 4'b0001;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check("s3_en", 32'(en3), 32'(i == 4));
      check("s3_d", d3, 32'h12345678);
      check("s3_ack", 32'(ack3), (i == 5) ? 1 : 0);
      check("s3_busy", 32'(busy3), 32'(i <= 5));
      if (i == 5) req3 = 4'b0000;
    end
    check("s3_err", 32'(err3), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
